// File: rtl/demux1to4_prio_dec.sv
// Re-expands a 3-bit priority code into an 8-bit one-hot or thermometer vector.
// The vector is steered into one of four single-entry lanes, each with a valid/ready handshake.
module demux1to4_prio_dec #(
  parameter int THERMO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] E,
  input  logic [1:0] S,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] O0,
  output logic [7:0] O1,
  output logic [7:0] O2,
  output logic [7:0] O3,
  output logic [3:0] o_valid,
  input  logic [3:0] o_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t r_state    [4];
  lane_state_t w_state_nxt[4];
  logic [7:0]  r_data     [4];
  logic [7:0]  w_data_nxt [4];
  logic [7:0]  w_dec;
  logic [3:0]  w_pop;
  logic [3:0]  w_load;
  logic        w_accept;

  // The shift is done 9 bits wide on a 4-bit amount so E=7 yields 9'h100 - 1 = 8'hFF.
  function automatic logic [7:0] decode(input logic [2:0] code);
    logic [3:0] amt;
    logic [8:0] wide;
    if (THERMO != 0) begin
      amt  = {1'b0, code} + 4'd1;
      wide = (9'd1 << amt) - 9'd1;
    end else begin
      amt  = {1'b0, code};
      wide = 9'd1 << amt;
    end
    return wide[7:0];
  endfunction

  assign w_dec    = decode(E);
  assign in_ready = ~o_valid[S] | o_ready[S];
  assign w_accept = in_valid & in_ready;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_pop[k]       = (r_state[k] == FULL) & o_ready[k];
      w_load[k]      = w_accept & (S == 2'(k));
      w_state_nxt[k] = r_state[k];
      w_data_nxt[k]  = r_data[k];
      if (w_load[k]) begin
        w_data_nxt[k] = w_dec;
      end else begin
        w_data_nxt[k] = r_data[k];
      end
      case (r_state[k])
        EMPTY: begin
          if (w_load[k]) begin
            w_state_nxt[k] = FULL;
          end else begin
            w_state_nxt[k] = EMPTY;
          end
        end
        FULL: begin
          if (w_pop[k] && !w_load[k]) begin
            w_state_nxt[k] = EMPTY;
          end else begin
            w_state_nxt[k] = FULL;
          end
        end
        default: w_state_nxt[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_state[k] <= EMPTY;
        r_data[k]  <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_data[k]  <= w_data_nxt[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      o_valid[k] = (r_state[k] == FULL);
    end
  end

  assign O0 = r_data[0];
  assign O1 = r_data[1];
  assign O2 = r_data[2];
  assign O3 = r_data[3];

endmodule
